// File: rtl/polar_to_point.sv
// polar_to_point: iterative CORDIC rotation-mode engine.
// Computes (x_org + r*cos(a), y_org + r*sin(a)) with one micro-rotation per clock.
// Units: positions and distance are x100, angle is centidegrees.
// Build option: define POLAR_SAT_EN to clamp each output axis to 16-bit range;
// when it is left undefined, each axis wraps in two's complement.
module polar_to_point #(
  parameter int ITER = 14,  // micro-rotations, legal 8..16
  parameter int IW   = 20   // signed x/y datapath width
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] x_org,
  input  logic signed [15:0] y_org,
  input  logic signed [15:0] r_in,
  input  logic signed [15:0] angle_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] x_out,
  output logic signed [15:0] y_out
);

  typedef enum logic [1:0] {IDLE, ROT, SUM, DONE} state_e;

  localparam int ZW = 17;
  localparam logic signed [ZW-1:0] Z_90  = 17'sd9000;
  localparam logic signed [ZW-1:0] Z_180 = 17'sd18000;
  localparam logic signed [ZW-1:0] Z_360 = 17'sd36000;
  localparam logic signed [IW-1:0] SAT_MAX = IW'(32767);
  localparam logic signed [IW-1:0] SAT_MIN = IW'(-32768);

  state_e               state_q, state_d;
  logic [4:0]           iter_q, iter_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic signed [15:0]   x_org_q, x_org_d, y_org_q, y_org_d;
  logic signed [15:0]   x_out_q, x_out_d, y_out_q, y_out_d;

  logic [15:0]          r_pos;
  logic [31:0]          rk_prod;
  logic signed [IW-1:0] rk;
  logic signed [ZW-1:0] a_ext, a_wrap;
  logic signed [IW-1:0] x_sh, y_sh;
  logic signed [IW-1:0] x_org_ext, y_org_ext;

  // Arctangent of 2^-i in centidegrees.
  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:  return 17'sd4500;
      4'd1:  return 17'sd2657;
      4'd2:  return 17'sd1404;
      4'd3:  return 17'sd713;
      4'd4:  return 17'sd358;
      4'd5:  return 17'sd179;
      4'd6:  return 17'sd90;
      4'd7:  return 17'sd45;
      4'd8:  return 17'sd22;
      4'd9:  return 17'sd11;
      4'd10: return 17'sd6;
      4'd11: return 17'sd3;
      4'd12: return 17'sd1;
      4'd13: return 17'sd1;
      default: return 17'sd0;
    endcase
  endfunction

  // Narrow an IW-bit sum to the 16-bit output format.
  function automatic logic signed [15:0] reduce16(input logic signed [IW-1:0] v);
`ifdef POLAR_SAT_EN
    if (v > SAT_MAX)      return 16'sh7fff;
    else if (v < SAT_MIN) return 16'sh8000;
    else                  return 16'(v);
`else
    return 16'(v);
`endif
  endfunction

  // Request preparation: gain-compensated radius and single-step angle wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    r_pos   = r_in[15] ? 16'd0 : r_in;
    rk_prod = 32'(r_pos) * 32'd19898 + 32'd16384;
    rk      = IW'(rk_prod >> 15);
    a_ext   = {angle_in[15], angle_in};
    a_wrap  = a_ext;
    if (a_ext > Z_180)       a_wrap = a_ext - Z_360;
    else if (a_ext < -Z_180) a_wrap = a_ext + Z_360;
  end

  // Shifted operands and sign-extended origin shared by ROT and SUM.
  always_comb begin
    x_sh      = x_q >>> iter_q;
    y_sh      = y_q >>> iter_q;
    x_org_ext = {{(IW-16){x_org_q[15]}}, x_org_q};
    y_org_ext = {{(IW-16){y_org_q[15]}}, y_org_q};
  end

  // Next-state and datapath update for IDLE -> ROT -> SUM -> DONE.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    x_org_d = x_org_q;
    y_org_d = y_org_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_org_d = x_org;
          y_org_d = y_org;
          iter_d  = '0;
          // Pre-rotate by +/-90 degrees so the residual angle is within CORDIC reach.
          if (a_wrap > Z_90) begin
            x_d = '0;
            y_d = rk;
            z_d = a_wrap - Z_90;
          end else if (a_wrap < -Z_90) begin
            x_d = '0;
            y_d = -rk;
            z_d = a_wrap + Z_90;
          end else begin
            x_d = rk;
            y_d = '0;
            z_d = a_wrap;
          end
          state_d = ROT;
        end
      end
      ROT: begin
        if (!z_q[ZW-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_lut(iter_q[3:0]);
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_lut(iter_q[3:0]);
        end
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'(ITER - 1)) state_d = SUM;
      end
      SUM: begin
        x_out_d = reduce16(x_q + x_org_ext);
        y_out_d = reduce16(y_q + y_org_ext);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: datapath registers are reset as well because the outputs must read zero after reset.
      state_q <= IDLE;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      x_org_q <= '0;
      y_org_q <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      x_org_q <= x_org_d;
      y_org_q <= y_org_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;

endmodule

// File: tb/tb_polar_to_point.sv
// Directed testbench for polar_to_point (default ITER=14, IW=20).
// Honours POLAR_SAT_EN in the overflow scenario.
module tb_polar_to_point;

  localparam int ITER = 14;
  // Arithmetic shifts floor negative operands, biasing results by a few LSB.
  localparam int TOL  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_org;
  logic signed [15:0] y_org;
  logic signed [15:0] r_in;
  logic signed [15:0] angle_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  polar_to_point #(.ITER(ITER), .IW(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_org    (x_org),
    .y_org    (y_org),
    .r_in     (r_in),
    .angle_in (angle_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .y_out    (y_out)
  );

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Present one request for a single edge.
  task automatic start_req(input int xo, input int yo, input int r, input int a);
    @(negedge clk);
    x_org    = 16'(xo);
    y_org    = 16'(yo);
    r_in     = 16'(r);
    angle_in = 16'(a);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges after accept until out_valid is seen (bounded).
  task automatic wait_result(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!out_valid && cycles < 100) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
  endtask

  // One-cycle out_ready pulse; returns just after the handshake edge.
  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x_org = '0; y_org = '0; r_in = '0; angle_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || x_out !== 16'sd0 || y_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b x=%0d y=%0d, want 1 0 0 0",
               in_ready, out_valid, x_out, y_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    start_req(0, 0, 500, 3687);
    out_ready = 1'b1;  // consumer already waiting before completion
    wait_result(cyc);
    checks++;
    if (cyc != ITER + 1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: %0d cycles (out_valid=%b), want %0d", cyc, out_valid, ITER + 1);
    end
    checks++;
    if (absd(int'(x_out), 400) > TOL) begin
      errors++;
      $display("FAIL basic_x: got %0d, want 400 +/-%0d", x_out, TOL);
    end
    checks++;
    if (absd(int'(y_out), 300) > TOL) begin
      errors++;
      $display("FAIL basic_y: got %0d, want 300 +/-%0d", y_out, TOL);
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_quadrants();
    int vx[5]  = '{1000,     0,      0,     0,  123};
    int vy[5]  = '{ 500,     0,      0,     0, -456};
    int vr[5]  = '{ 361,   100,    100,   100, -500};
    int va[5]  = '{-12369, 9000, -18000, 27000, 4000};
    int ex[5]  = '{ 800,     0,   -100,     0,  123};
    int ey[5]  = '{ 200,   100,      0,  -100, -456};
    int cyc;
    for (int k = 0; k < 5; k++) begin
      start_req(vx[k], vy[k], vr[k], va[k]);
      wait_result(cyc);
      checks++;
      if (!out_valid || absd(int'(x_out), ex[k]) > TOL || absd(int'(y_out), ey[k]) > TOL) begin
        errors++;
        $display("FAIL quadrant_vec%0d: out_valid=%b got (%0d,%0d), want (%0d,%0d) +/-%0d",
                 k, out_valid, x_out, y_out, ex[k], ey[k], TOL);
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic signed [15:0] hx, hy;
    start_req(0, 400, 1020, -1131);
    wait_result(cyc);
    checks++;
    if (!out_valid || absd(int'(x_out), 1000) > TOL || absd(int'(y_out), 200) > TOL) begin
      errors++;
      $display("FAIL bp_result: out_valid=%b got (%0d,%0d), want (1000,200) +/-%0d",
               out_valid, x_out, y_out, TOL);
    end
    hx = x_out;
    hy = y_out;
    // Offer a competing request while the result is stalled.
    x_org = 16'sd0; y_org = 16'sd0; r_in = 16'sd5000; angle_in = 16'sd0;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== hx || y_out !== hy) begin
        errors++;
        $display("FAIL bp_hold_c%0d: valid=%b ready=%b (%0d,%0d), want 1 0 (%0d,%0d)",
                 c, out_valid, in_ready, x_out, y_out, hx, hy);
      end
    end
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    // The ignored request must not surface later.
    repeat (ITER + 5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_queue: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    start_req(32000, 0, 2000, 0);
    wait_result(cyc);
`ifdef POLAR_SAT_EN
    checks++;
    if (!out_valid || x_out !== 16'sd32767) begin
      errors++;
      $display("FAIL sat_x: out_valid=%b got %0d, want 32767", out_valid, x_out);
    end
`else
    checks++;
    if (!out_valid || absd(int'(x_out), -31536) > TOL) begin
      errors++;
      $display("FAIL wrap_x: out_valid=%b got %0d, want -31536 +/-%0d", out_valid, x_out, TOL);
    end
`endif
    checks++;
    if (absd(int'(y_out), 0) > TOL) begin
      errors++;
      $display("FAIL ovf_y: got %0d, want 0 +/-%0d", y_out, TOL);
    end
    drain();
  endtask

  task automatic test_reset_mid_rot();
    int cyc;
    start_req(1000, 500, 361, -12369);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_flags: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || x_out !== 16'sd0 || y_out !== 16'sd0) begin
      errors++;
      $display("FAIL rst_mid_rot: in_ready=%b out_valid=%b x=%0d y=%0d, want 1 0 0 0",
               in_ready, out_valid, x_out, y_out);
    end
    // Reset and request on the same edge: reset wins.
    x_org = 16'sd0; y_org = 16'sd0; r_in = 16'sd500; angle_in = 16'sd0;
    rst = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 begin rst = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_vs_valid: in_ready=%b, want 1", in_ready);
    end
    start_req(0, 400, 1020, -1131);
    wait_result(cyc);
    checks++;
    if (cyc != ITER + 1 || absd(int'(x_out), 1000) > TOL || absd(int'(y_out), 200) > TOL) begin
      errors++;
      $display("FAIL post_rst_req: %0d cycles (%0d,%0d), want %0d (1000,200) +/-%0d",
               cyc, x_out, y_out, ITER + 1, TOL);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_quadrants();
    test_backpressure();
    test_saturation();
    test_reset_mid_rot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/polar_to_point.md
# polar_to_point

Iterative CORDIC rotation-mode engine: the inverse of the vectoring-mode distance/angle path. Given an origin point, a distance and a heading angle, it produces the destination point x = x_org + r·cos θ, y = y_org + r·sin θ. It uses the same fixed-point conventions as the vectoring core, so a vectoring result can be fed straight back to reconstruct the second point. One CORDIC micro-rotation is performed per clock, with valid/ready handshakes on both sides.

## Interface
- ITER, 14, number of micro-rotations (legal 8..16)
- IW, 20, internal signed datapath width for x/y (guard bits above 16)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request; high only in IDLE
- x_org  in  16  signed origin x, value ×100 (4_00 = 4.00)
- y_org  in  16  signed origin y, value ×100
- r_in  in  16  signed distance ×100; negative values are treated as 0
- angle_in  in  16  signed angle in centidegrees, -18000..18000
- out_valid  out  1  result present; held until accepted
- out_ready  in  1  consumer accepts the result
- x_out  out  16  signed destination x ×100
- y_out  out  16  signed destination y ×100

## Operation
- States: IDLE → ROT → SUM → DONE → IDLE.
- IDLE: in_ready=1. On in_valid, latch the origin and pre-scale the radius:
  - rk = (r·19898 + 16384) >>> 15, which compensates the CORDIC gain (1/1.6468).
  - Wrap the angle once: a > 18000 → a−36000; a < −18000 → a+36000.
  - Quadrant pre-rotation:
    - a > 9000: x=0, y=rk, z=a−9000.
    - a < −9000: x=0, y=−rk, z=a+9000.
    - Otherwise: x=rk, y=0, z=a.
  - Clear i=0 and go to ROT.
- ROT, one micro-rotation per cycle:
  - d = (z ≥ 0) ? +1 : −1.
  - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atan[i].
  - i increments each cycle. After iteration ITER−1, go to SUM.
- atan table in centidegrees, i=0..15: 4500, 2657, 1404, 713, 358, 179, 90, 45, 22, 11, 6, 3, 1, 1, 0, 0.
- All x/y arithmetic is IW bits with arithmetic shifts; z is 17-bit signed.
- SUM: x_out = x_org + x, y_out = y_org + y, each computed at IW bits then reduced to 16 bits per Configuration. Go to DONE.
- DONE: out_valid=1 and outputs stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE; there is no queuing.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, x_out=0, y_out=0, i=0.
- Accept at edge k (in_valid & in_ready). ROT occupies edges k+1..k+ITER. SUM register at edge k+ITER+1. out_valid is high after edge k+ITER+1.
- Latency is ITER+1 cycles from accept to out_valid (15 at default).
- Handshake at edge m (out_valid & out_ready) → in_ready is high after edge m. Minimum request spacing is ITER+3 cycles.
- out_ready held high before completion: out_valid is still asserted for at least one cycle.
- rst in any state: return to IDLE next edge, discard the in-flight request, clear outputs. There is no partial result.
- Simultaneous rst and in_valid: rst wins and the request is not accepted.
- Accuracy: |error| ≤ 2 LSB per axis for r ≤ 10000 at ITER=14.

## Configuration
- POLAR_SAT_EN defined: the SUM stage clamps each axis to [−32768, 32767].
- POLAR_SAT_EN undefined: the SUM stage truncates to the low 16 bits (two's-complement wrap). This saves logic when callers guarantee range.

## Test plan
- Origin (0,0), r=500, angle=3687 → (400,300) ±2; out_valid rises exactly 15 cycles after accept.
- Origin (1000,500), r=361, angle=−12369 → (800,200) ±2. This exercises the negative quadrant pre-rotation and is the round trip of a vectoring result.
- Origin (0,400), r=1020, angle=−1131 → (1000,200) ±2. Angles 9000 and −18000 with r=100 → (0,100) and (−100,0) ±1.
- Backpressure: out_ready low for 5 cycles after out_valid → outputs and out_valid hold, in_ready stays 0, a new in_valid is ignored. out_ready=1 → in_ready=1 on the next cycle.
- Origin (32000,0), r=2000, angle=0 → x_out=32767 with POLAR_SAT_EN; x_out=−31536 without.
- Assert rst in cycle 6 of ROT → the next cycle shows IDLE with out_valid=0 and outputs 0. The next request then completes normally with its own values.
